// File: rtl/clock_gate_ctrl.sv
// Period-aligned clock-enable gating per channel, driven by clock_gen strobes.
// Optional stall detection: define CLOCK_GATE_STALL_DETECT_EN.
module clock_gate_ctrl #(
    parameter int clock_number = 8,
    parameter int stall_limit  = 256
) (
    input  logic                    mainclock,
    input  logic                    reset,
    input  logic [clock_number-1:0] tick,
    input  logic [clock_number-1:0] req_en,
    output logic [clock_number-1:0] clk_en,
    output logic [clock_number-1:0] running,
    output logic                    busy,
    output logic [clock_number-1:0] stall
);

    typedef enum logic [1:0] {
        ST_STOPPED,
        ST_ARMING,
        ST_RUNNING,
        ST_DRAINING
    } state_e;

    state_e state_q [clock_number];
    state_e state_d [clock_number];

    logic [clock_number-1:0] clk_en_q, clk_en_d;
    logic [clock_number-1:0] run_q, run_d;
    logic [clock_number-1:0] wait_d;
    logic                    busy_q, busy_d;
    logic [clock_number-1:0] stall_q, stall_d;

    always_comb begin
        for (int j = 0; j < clock_number; j++) begin
            state_d[j]  = state_q[j];
            clk_en_d[j] = 1'b0;
            unique case (state_q[j])
                ST_STOPPED: begin
                    if (req_en[j]) state_d[j] = ST_ARMING;
                end
                ST_ARMING: begin
                    // A dropped request wins over a coincident strobe.
                    if (!req_en[j]) begin
                        state_d[j] = ST_STOPPED;
                    end else if (tick[j]) begin
                        state_d[j]  = ST_RUNNING;
                        clk_en_d[j] = 1'b1;
                    end
                end
                ST_RUNNING: begin
                    clk_en_d[j] = tick[j];
                    if (!req_en[j])
                        state_d[j] = tick[j] ? ST_STOPPED : ST_DRAINING;
                end
                ST_DRAINING: begin
                    if (req_en[j]) begin
                        state_d[j]  = ST_RUNNING;
                        clk_en_d[j] = tick[j];
                    end else if (tick[j]) begin
                        state_d[j]  = ST_STOPPED;
                        clk_en_d[j] = 1'b1;
                    end
                end
                default: state_d[j] = ST_STOPPED;
            endcase
            run_d[j]  = (state_d[j] == ST_RUNNING) ||
                        (state_d[j] == ST_DRAINING);
            wait_d[j] = (state_d[j] == ST_ARMING) ||
                        (state_d[j] == ST_DRAINING);
        end
        busy_d = |wait_d;
    end

`ifdef CLOCK_GATE_STALL_DETECT_EN
    localparam int CW = $clog2(stall_limit + 1);
    localparam logic [CW-1:0] LIM = CW'(stall_limit);

    logic [CW-1:0] cnt_q [clock_number];
    logic [CW-1:0] cnt_d [clock_number];

    always_comb begin
        for (int j = 0; j < clock_number; j++) begin
            cnt_d[j]   = cnt_q[j];
            stall_d[j] = stall_q[j];
            // Counting only runs while already waiting, so entry starts at 0.
            if (tick[j] || !((state_q[j] == ST_ARMING) ||
                             (state_q[j] == ST_DRAINING))) begin
                cnt_d[j] = '0;
            end else if (cnt_q[j] != LIM) begin
                cnt_d[j] = cnt_q[j] + 1'b1;
            end
            if (state_q[j] == ST_ARMING && !req_en[j])
                stall_d[j] = 1'b0;
            else if (cnt_d[j] == LIM)
                stall_d[j] = 1'b1;
        end
    end

    always_ff @(posedge mainclock) begin
        for (int j = 0; j < clock_number; j++) begin
            if (reset) cnt_q[j] <= '0;
            else       cnt_q[j] <= cnt_d[j];
        end
    end
`else
    always_comb begin
        stall_d = '0;
    end
`endif

    always_ff @(posedge mainclock) begin
        if (reset) begin
            for (int j = 0; j < clock_number; j++)
                state_q[j] <= ST_STOPPED;
            clk_en_q <= '0;
            run_q    <= '0;
            busy_q   <= 1'b0;
            stall_q  <= '0;
        end else begin
            for (int j = 0; j < clock_number; j++)
                state_q[j] <= state_d[j];
            clk_en_q <= clk_en_d;
            run_q    <= run_d;
            busy_q   <= busy_d;
            stall_q  <= stall_d;
        end
    end

    assign clk_en  = clk_en_q;
    assign running = run_q;
    assign busy    = busy_q;
    assign stall   = stall_q;

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl with immediate-assertion checks.
module tb_clock_gate_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tick;
    logic [7:0] req;
    logic [7:0] clk_en;
    logic [7:0] running;
    logic       busy;
    logic [7:0] stall;

    int checks = 0;
    int errors = 0;

    clock_gate_ctrl #(
        .clock_number(8),
        .stall_limit (4)
    ) dut (
        .mainclock(clk),
        .reset    (rst),
        .tick     (tick),
        .req_en   (req),
        .clk_en   (clk_en),
        .running  (running),
        .busy     (busy),
        .stall    (stall)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] ce,
                        input logic [7:0] rn, input logic bz);
        chk({tag, ".clk_en"}, clk_en, ce);
        chk({tag, ".running"}, running, rn);
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, bz});
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        tick = 8'h00;
        req  = 8'h00;
        step();
        chk3("rst", 8'h00, 8'h00, 1'b0);
        chk("rst.stall", stall, 8'h00);
        rst = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        req  = 8'hFF;
        tick = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("rst_hold", 8'h00, 8'h00, 1'b0);
            chk("rst_hold.stall", stall, 8'h00);
        end
        rst = 1'b0;
        step();
        chk("rel1.clk_en", clk_en, 8'h00);
        chk("rel1.running", running, 8'h00);
        step();
        chk3("rel2", 8'hFF, 8'hFF, 1'b0);
        req  = 8'h00;
        tick = 8'h00;
        step();
        chk3("all_drain", 8'h00, 8'hFF, 1'b1);
        tick = 8'hFF;
        step();
        chk3("all_final", 8'hFF, 8'h00, 1'b0);
        tick = 8'h00;
        step();
        chk3("all_idle", 8'h00, 8'h00, 1'b0);

        do_reset();
        req  = 8'h01;
        tick = 8'h00;
        step();
        chk3("ch0_arm", 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk3("ch0_wait", 8'h00, 8'h00, 1'b1);
        end
        tick = 8'h01;
        step();
        chk3("ch0_first", 8'h01, 8'h01, 1'b0);
        for (int p = 0; p < 2; p++) begin
            tick = 8'h00;
            for (int i = 0; i < 3; i++) begin
                step();
                chk3("ch0_gap", 8'h00, 8'h01, 1'b0);
            end
            tick = 8'h01;
            step();
            chk3("ch0_pulse", 8'h01, 8'h01, 1'b0);
        end

        do_reset();
        req  = 8'h04;
        tick = 8'h04;
        step();
        chk3("ch2_arm", 8'h00, 8'h00, 1'b1);
        step();
        chk3("ch2_run", 8'h04, 8'h04, 1'b0);
        tick = 8'h00;
        step();
        chk3("ch2_gap", 8'h00, 8'h04, 1'b0);
        req = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("ch2_drain", 8'h00, 8'h04, 1'b1);
        end
        tick = 8'h04;
        step();
        chk3("ch2_final", 8'h04, 8'h00, 1'b0);
        tick = 8'h00;
        step();
        chk3("ch2_idle", 8'h00, 8'h00, 1'b0);

        do_reset();
        req = 8'h0A;
        step();
        chk3("co_arm", 8'h00, 8'h00, 1'b1);
        tick = 8'h08;
        step();
        chk3("co_ch3run", 8'h08, 8'h08, 1'b1);
        req  = 8'h00;
        tick = 8'h0A;
        step();
        chk3("co_stop", 8'h08, 8'h00, 1'b0);
        tick = 8'h00;
        step();
        chk3("co_idle", 8'h00, 8'h00, 1'b0);

        do_reset();
        req  = 8'h10;
        tick = 8'h10;
        step();
        step();
        chk3("ch4_run", 8'h10, 8'h10, 1'b0);
        tick = 8'h00;
        req  = 8'h00;
        step();
        chk3("ch4_drain", 8'h00, 8'h10, 1'b1);
        req = 8'h10;
        step();
        chk3("ch4_cancel", 8'h00, 8'h10, 1'b0);
        step();
        chk3("ch4_gap", 8'h00, 8'h10, 1'b0);
        tick = 8'h10;
        step();
        chk3("ch4_pulse", 8'h10, 8'h10, 1'b0);

        do_reset();
        req = 8'h01;
        step();
        chk3("abort_arm", 8'h00, 8'h00, 1'b1);
        rst  = 1'b1;
        tick = 8'h01;
        step();
        chk3("abort_rst", 8'h00, 8'h00, 1'b0);
        rst = 1'b0;

        do_reset();
        req  = 8'h40;
        tick = 8'h40;
        step();
        chk3("div1_arm", 8'h00, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk3("div1_run", 8'h40, 8'h40, 1'b0);
        end

        do_reset();
        req  = 8'h20;
        tick = 8'h00;
        for (int i = 1; i <= 6; i++) begin
            step();
`ifdef CLOCK_GATE_STALL_DETECT_EN
            chk("stall_wait", stall, (i >= 5) ? 8'h20 : 8'h00);
`else
            chk("stall_off", stall, 8'h00);
`endif
        end
        req = 8'h00;
        step();
        chk("stall_clr", stall, 8'h00);
        chk3("stall_stop", 8'h00, 8'h00, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
